// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mc_restoring_div.sv
// Iterative restoring remainder datapath: one dividend bit is shifted in per step.
// The parent decides when to load and step and when the remainder is final.
module restoring_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_next_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   remStep;

    // The trial value needs one extra bit: it can reach 2*divisor-1 before restoring.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]};
        remStep = trial;
        if (trial >= {1'b0, div_q}) begin
            remStep = trial - {1'b0, div_q};
        end
        rem_next_o = remStep[WIDTH-1:0];
    end

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = a_i;
            div_d = b_i;
        end else if (step_i) begin
            rem_d = rem_next_o;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative unsigned MOD,
// start/busy/done handshake with registered Result and flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit SLT_SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] Result,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             dbz_q, dbz_d;

    logic             divLoad;
    logic             divStep;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             lt;
    logic [WIDTH-1:0] opResult;
    logic             opCarry;

    restoring_div #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .load_i     (divLoad),
        .step_i     (divStep),
        .a_i        (A),
        .b_i        (B),
        .rem_next_o (remNext)
    );

    // Bit WIDTH of the widened difference is the unsigned borrow, reused by unsigned SLT.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        diff     = {1'b0, A} - {1'b0, B};
        lt       = (SLT_SIGNED != 1'b0) ? ($signed(A) < $signed(B)) : diff[WIDTH];
        opResult = '0;
        opCarry  = 1'b0;
        case (ALUop)
            OP_AND:  opResult = A & B;
            OP_OR:   opResult = A | B;
            OP_XOR:  opResult = A ^ B;
            OP_NOR:  opResult = ~(A | B);
            OP_SLT:  opResult = {{(WIDTH-1){1'b0}}, lt};
            OP_ADD:  begin opResult = sum[WIDTH-1:0];  opCarry = sum[WIDTH];  end
            OP_SUB:  begin opResult = diff[WIDTH-1:0]; opCarry = diff[WIDTH]; end
            default: opResult = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        divLoad  = 1'b0;
        divStep  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (ALUop != OP_MOD) begin
                        result_d = opResult;
                        zero_d   = (opResult == '0);
                        carry_d  = opCarry;
                        dbz_d    = 1'b0;
                        done_d   = 1'b1;
                    end else if (B == '0) begin
                        result_d = A;
                        zero_d   = (A == '0);
                        carry_d  = 1'b0;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        divLoad  = 1'b1;
                        cnt_d    = CW'(WIDTH - 1);
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                divStep = 1'b1;
                if (cnt_q == '0) begin
                    result_d = remNext;
                    zero_d   = (remNext == '0);
                    carry_d  = 1'b0;
                    dbz_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Result = result_q;
    assign done   = done_q;
    assign busy   = (state_q == ST_RUN);
    assign zero   = zero_q;
    assign carry  = carry_q;
    assign dbz    = dbz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: 32-bit unsigned-SLT, 32-bit signed-SLT and 8-bit instances.
module tb_alu_mc;

    logic clk;
    logic rst;

    logic        start32, done32, busy32, zero32, carry32, dbz32;
    logic [31:0] a32, b32, res32;
    logic [2:0]  op32;

    logic        startS, doneS, busyS, zeroS, carryS, dbzS;
    logic [31:0] aS, bS, resS;
    logic [2:0]  opS;

    logic        start8, done8, busy8, zero8, carry8, dbz8;
    logic [7:0]  a8, b8, res8;
    logic [2:0]  op8;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        carry;
    } vec_t;

    vec_t vecs[12];

    alu_mc #(.WIDTH(32), .SLT_SIGNED(1'b0)) dutU (
        .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32), .ALUop(op32),
        .Result(res32), .done(done32), .busy(busy32), .zero(zero32), .carry(carry32), .dbz(dbz32)
    );

    alu_mc #(.WIDTH(32), .SLT_SIGNED(1'b1)) dutS (
        .clk(clk), .rst(rst), .start(startS), .A(aS), .B(bS), .ALUop(opS),
        .Result(resS), .done(doneS), .busy(busyS), .zero(zeroS), .carry(carryS), .dbz(dbzS)
    );

    alu_mc #(.WIDTH(8), .SLT_SIGNED(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .ALUop(op8),
        .Result(res8), .done(done8), .busy(busy8), .zero(zero8), .carry(carry8), .dbz(dbz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One-cycle op on the unsigned 32-bit instance; returns sampled #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op32 = op; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
    endtask

    task automatic runMod32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cycles;
        int busyCnt;
        @(negedge clk);
        op32 = 3'b111; a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        cycles  = 0;
        busyCnt = 0;
        checkOutput("mod_busy_after_start", {31'd0, busy32}, 32'd1);
        // Stray start pulses with other ops and B=0 must not disturb the iteration.
        while (!done32 && cycles < 100) begin
            if (busy32) busyCnt++;
            start32 = cycles[0];
            op32    = cycles[0] ? 3'b101 : 3'b111;
            a32     = $urandom;
            b32     = 32'd0;
            @(posedge clk);
            #1;
            cycles++;
        end
        start32 = 1'b0;
        checkOutput("mod_latency", cycles, 32'd32);
        checkOutput("mod_busy_cycles", busyCnt, 32'd32);
        checkOutput("mod_result", res32, exp);
        checkOutput("mod_dbz", {31'd0, dbz32}, 32'd0);
        checkOutput("mod_busy_at_done", {31'd0, busy32}, 32'd0);
        checkOutput("mod_zero", {31'd0, zero32}, {31'd0, exp == 32'd0});
        @(posedge clk);
        #1;
        checkOutput("mod_done_pulse_len", {31'd0, done32}, 32'd0);
    endtask

    initial begin
        int cycles;
        int doneSeen;

        vecs[0]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
        vecs[5]  = '{3'b011, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
        vecs[7]  = '{3'b100, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b1};
        vecs[10] = '{3'b110, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0};

        rst = 1'b1;
        start32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
        startS  = 1'b0; aS  = '0; bS  = '0; opS  = '0;
        start8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;

        #3;
        checkOutput("rst_result", res32, 32'd0);
        checkOutput("rst_done",   {31'd0, done32}, 32'd0);
        checkOutput("rst_busy",   {31'd0, busy32}, 32'd0);
        checkOutput("rst_flags",  {29'd0, zero32, carry32, dbz32}, 32'd0);
        checkOutput("rst_result8", {24'd0, res8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_done", i),   {31'd0, done32}, 32'd1);
            checkOutput($sformatf("vec%0d_result", i), res32, vecs[i].res);
            checkOutput($sformatf("vec%0d_zero", i),   {31'd0, zero32}, {31'd0, vecs[i].zero});
            checkOutput($sformatf("vec%0d_carry", i),  {31'd0, carry32}, {31'd0, vecs[i].carry});
            checkOutput($sformatf("vec%0d_dbz", i),    {31'd0, dbz32}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("done_drops", {31'd0, done32}, 32'd0);
        checkOutput("result_holds", res32, 32'd0);

        // Divide by zero completes in one edge without ever going busy.
        applyStimulus(3'b111, 32'd5, 32'd0);
        checkOutput("dbz_done",   {31'd0, done32}, 32'd1);
        checkOutput("dbz_result", res32, 32'd5);
        checkOutput("dbz_flag",   {31'd0, dbz32}, 32'd1);
        checkOutput("dbz_busy",   {31'd0, busy32}, 32'd0);
        checkOutput("dbz_zero",   {31'd0, zero32}, 32'd0);
        applyStimulus(3'b101, 32'd2, 32'd3);
        checkOutput("dbz_cleared", {31'd0, dbz32}, 32'd0);

        runMod32(32'd100, 32'd7, 32'd2);

        // Reset mid-MOD aborts the iteration and no done pulse follows.
        @(negedge clk);
        op32 = 3'b111; a32 = 32'd1000; b32 = 32'd13; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy",   {31'd0, busy32}, 32'd0);
        checkOutput("abort_result", res32, 32'd0);
        checkOutput("abort_done",   {31'd0, done32}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32) doneSeen++;
        end
        checkOutput("abort_no_done", doneSeen, 32'd0);
        runMod32(32'd1000, 32'd13, 32'd12);

        // Signed SLT instance.
        @(negedge clk);
        opS = 3'b100; aS = 32'hFFFFFFFF; bS = 32'd1; startS = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("sslt_neg_lt_pos", resS, 32'd1);
        checkOutput("sslt_done", {31'd0, doneS}, 32'd1);
        aS = 32'd1; bS = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        startS = 1'b0;
        checkOutput("sslt_pos_lt_neg", resS, 32'd0);
        checkOutput("sslt_zero", {31'd0, zeroS}, 32'd1);

        // 8-bit instance: MOD latency equals WIDTH, then ADD in the done cycle.
        @(negedge clk);
        op8 = 3'b111; a8 = 8'd200; b8 = 8'd9; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        cycles = 0;
        while (!done8 && cycles < 50) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("mod8_latency", cycles, 32'd8);
        checkOutput("mod8_result", {24'd0, res8}, 32'd2);
        checkOutput("mod8_busy", {31'd0, busy8}, 32'd0);
        op8 = 3'b101; a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checkOutput("b2b_done",   {31'd0, done8}, 32'd1);
        checkOutput("b2b_result", {24'd0, res8}, 32'd30);
        checkOutput("b2b_carry",  {31'd0, carry8}, 32'd0);
        @(negedge clk);
        op8 = 3'b101; a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        checkOutput("add8_result", {24'd0, res8}, 32'd44);
        checkOutput("add8_carry",  {31'd0, carry8}, 32'd1);
        checkOutput("add8_dbz",    {31'd0, dbz8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
